// File: rtl/simple_spi_slave_wb_if.sv
// rtl/simple_spi_slave_wb_if.sv - Wishbone register bus bundle for the SPI slave
interface simple_spi_slave_wb_if;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_adr_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;

   modport master (
      output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_dat_i, wb_adr_i,
      input  wb_ack_o, wb_dat_o
   );

   modport slave (
      input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_dat_i, wb_adr_i,
      output wb_ack_o, wb_dat_o
   );
endinterface

// File: rtl/simple_spi_slave_wb.sv
// rtl/simple_spi_slave_wb.sv - byte-oriented SPI target with Wishbone registers
// Optional echo of received bytes when SPI_SLAVE_LOOPBACK_EN is defined (CONFIG bit4).
module simple_spi_slave_wb #(
   parameter logic [31:0] BASE_ADR = 32'h2400_0000,
   parameter logic [7:0]  CONFIG   = 8'h00,
   parameter logic [7:0]  DATA     = 8'h04,
   parameter logic [7:0]  STATUS   = 8'h08
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   simple_spi_slave_wb_if.slave wb,
   input  logic                 sck,
   input  logic                 csb,
   input  logic                 sdi,
   output logic                 sdo,
   output logic                 sdoenb,
   output logic                 irq
);

`ifdef SPI_SLAVE_LOOPBACK_EN
   localparam int CFG_W = 5;
`else
   localparam int CFG_W = 4;
`endif

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t             state;
   state_t             state_nxt;

   logic [1:0]         csb_sync;
   logic [1:0]         sck_sync;
   logic [1:0]         sdi_sync;
   logic               csb_d;
   logic               sck_d;
   logic [1:0]         settle;
   logic               armed;

   logic [CFG_W-1:0]   cfg;
   logic [7:0]         tx_buf;
   logic [7:0]         tx_shift;
   logic [7:0]         rx_buf;
   logic [7:0]         rx_shift;
   logic               tx_full;
   logic               rx_full;
   logic               overrun;
   logic               underrun;
   logic [2:0]         bit_cnt;
   logic               reload_pend;

   logic               enable;
   logic               mlb;
   logic               invsck;
   logic               irq_ena;
   logic               csb_fall;
   logic               csb_rise;
   logic               sck_rise;
   logic               sck_fall;
   logic               start;
   logic               stop;
   logic               sample;
   logic               launch;
   logic               busy;

   logic               acc;
   logic               wr;
   logic               rd;
   logic               hit_cfg;
   logic               hit_data;
   logic               hit_stat;
   logic [7:0]         load_val;
   logic [7:0]         rx_byte;
   logic               unused_bits;

   assign enable  = cfg[0];
   assign mlb     = cfg[1];
   assign invsck  = cfg[2];
   assign irq_ena = cfg[3];

   assign unused_bits = ^{wb.wb_sel_i[3:1], wb.wb_dat_i[31:8]};

   // The csb falling edge is only honoured once csb has been seen high after
   // reset, so a chip select held low across reset cannot start a transfer.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         csb_sync <= 2'b11;
         sck_sync <= 2'b00;
         sdi_sync <= 2'b00;
         csb_d    <= 1'b1;
         sck_d    <= 1'b0;
         settle   <= 2'd0;
         armed    <= 1'b0;
      end else begin
         csb_sync <= {csb_sync[0], csb};
         sck_sync <= {sck_sync[0], sck};
         sdi_sync <= {sdi_sync[0], sdi};
         csb_d    <= csb_sync[1];
         sck_d    <= sck_sync[1];
         if (settle != 2'd3)
            settle <= settle + 2'd1;
         if (settle == 2'd3 && csb_sync[1])
            armed <= 1'b1;
      end
   end

   assign csb_fall = armed & csb_d & ~csb_sync[1];
   assign csb_rise = ~csb_d & csb_sync[1];
   assign sck_rise = sck_sync[1] & ~sck_d;
   assign sck_fall = ~sck_sync[1] & sck_d;

   assign hit_cfg  = (wb.wb_adr_i == (BASE_ADR | {24'h0, CONFIG}));
   assign hit_data = (wb.wb_adr_i == (BASE_ADR | {24'h0, DATA}));
   assign hit_stat = (wb.wb_adr_i == (BASE_ADR | {24'h0, STATUS}));
   assign acc      = wb.wb_ack_o & wb.wb_stb_i & wb.wb_cyc_i;
   assign wr       = acc & wb.wb_we_i;
   assign rd       = acc & ~wb.wb_we_i;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      stop      = 1'b0;
      sample    = 1'b0;
      launch    = 1'b0;
      sdoenb    = 1'b1;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (enable && csb_fall) begin
               start     = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            sdoenb = 1'b0;
            busy   = 1'b1;
            if (csb_rise || !enable) begin
               stop      = 1'b1;
               state_nxt = IDLE;
            end else begin
               sample = invsck ? sck_fall : sck_rise;
               launch = invsck ? sck_rise : sck_fall;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wb.wb_dat_o = 32'h0;
      if (wb.wb_ack_o) begin
         if (hit_cfg)
            wb.wb_dat_o = {{(32-CFG_W){1'b0}}, cfg};
         else if (hit_data)
            wb.wb_dat_o = {24'h0, rx_buf};
         else if (hit_stat)
            wb.wb_dat_o = {27'h0, busy, underrun, overrun, tx_full, rx_full};
      end
   end

   assign load_val = tx_full ? tx_buf : 8'hFF;
   assign rx_byte  = mlb ? {sdi_sync[1], rx_shift[7:1]} : {rx_shift[6:0], sdi_sync[1]};

   // Assignment order encodes priority: clears first, then loads, then the
   // later sets (byte completion, new data, overrun/underrun) win.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb.wb_ack_o <= 1'b0;
         cfg         <= '0;
         tx_buf      <= 8'h00;
         tx_shift    <= 8'h00;
         rx_buf      <= 8'h00;
         rx_shift    <= 8'h00;
         tx_full     <= 1'b0;
         rx_full     <= 1'b0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
         bit_cnt     <= 3'd0;
         reload_pend <= 1'b0;
         sdo         <= 1'b0;
         irq         <= 1'b0;
      end else begin
         wb.wb_ack_o <= wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;

         if (wr && hit_cfg && wb.wb_sel_i[0])
            cfg <= wb.wb_dat_i[CFG_W-1:0];
         if (wr && hit_stat) begin
            if (wb.wb_dat_i[2]) overrun  <= 1'b0;
            if (wb.wb_dat_i[3]) underrun <= 1'b0;
         end
         if (rd && hit_data)
            rx_full <= 1'b0;

         if (start || (launch && reload_pend)) begin
            tx_shift    <= load_val;
            sdo         <= mlb ? load_val[0] : load_val[7];
            reload_pend <= 1'b0;
            if (tx_full)
               tx_full <= 1'b0;
            else
               underrun <= 1'b1;
         end else if (launch) begin
            tx_shift <= mlb ? {1'b1, tx_shift[7:1]} : {tx_shift[6:0], 1'b1};
            sdo      <= mlb ? tx_shift[1] : tx_shift[6];
         end

         if (wr && hit_data) begin
            tx_buf  <= wb.wb_dat_i[7:0];
            tx_full <= 1'b1;
         end

         if (sample) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               reload_pend <= 1'b1;
               if (rx_full) begin
                  overrun <= 1'b1;
               end else begin
                  rx_buf  <= rx_byte;
                  rx_full <= 1'b1;
               end
`ifdef SPI_SLAVE_LOOPBACK_EN
               if (cfg[4]) begin
                  tx_buf  <= rx_byte;
                  tx_full <= 1'b1;
               end
`endif
            end
         end

         if (start || stop) begin
            bit_cnt <= 3'd0;
            if (stop)
               reload_pend <= 1'b0;
         end

         irq <= irq_ena & (rx_full | overrun);
      end
   end

endmodule
